// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: 6-state T-ring plus opcode decode producing the
// datapath control strobes, halt latch and ALU carry/zero flag registers.
module sap_controller #(
    parameter int unsigned OP_WIDTH  = 4,
    parameter int unsigned SKIP_IDLE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic                alu_c,
    input  logic                alu_z,
    output logic [5:0]          t_state,
    output logic                pc_enable,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mar_latch,
    output logic                ram_enable,
    output logic                ir_latch,
    output logic                ir_enable,
    output logic                a_latch,
    output logic                a_enable,
    output logic                b_latch,
    output logic                alu_enable,
    output logic                alu_sub,
    output logic                out_latch,
    output logic                halt,
    output logic                c_flag,
    output logic                z_flag
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_t;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_JMP = 4'h3,
        OP_JZ  = 4'h4,
        OP_JC  = 4'h5,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    tstate_t state_q, state_d;
    logic    halt_q, halt_d;
    logic    c_q, c_d;
    logic    z_q, z_d;
    logic    is_arith;
    logic    last_active;

    assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= T1;
            halt_q  <= 1'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    // Last T-state carrying any control for the current opcode; NOP still visits T4.
    always_comb begin
        last_active = 1'b0;
        if (state_q == T4) begin
            case (opcode)
                OP_LDA, OP_ADD, OP_SUB, OP_HLT: last_active = 1'b0;
                default:                        last_active = 1'b1;
            endcase
        end else if (state_q == T5) begin
            last_active = (opcode == OP_LDA);
        end
    end

    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        c_d     = c_q;
        z_d     = z_q;
        if (step && !halt_q) begin
            if (state_q == T4 && opcode == OP_HLT) begin
                halt_d = 1'b1;
            end else begin
                case (state_q)
                    T1:      state_d = T2;
                    T2:      state_d = T3;
                    T3:      state_d = T4;
                    T4:      state_d = T5;
                    T5:      state_d = T6;
                    default: state_d = T1;
                endcase
                if (SKIP_IDLE != 0 && last_active) begin
                    state_d = T1;
                end
            end
            if (state_q == T6 && is_arith) begin
                c_d = alu_c;
                z_d = alu_z;
            end
        end
    end

    always_comb begin
        pc_enable  = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mar_latch  = 1'b0;
        ram_enable = 1'b0;
        ir_latch   = 1'b0;
        ir_enable  = 1'b0;
        a_latch    = 1'b0;
        a_enable   = 1'b0;
        b_latch    = 1'b0;
        alu_enable = 1'b0;
        alu_sub    = 1'b0;
        out_latch  = 1'b0;
        if (!halt_q) begin
            case (state_q)
                T1: begin
                    pc_enable = 1'b1;
                    mar_latch = 1'b1;
                end
                T2: pc_inc = 1'b1;
                T3: begin
                    ram_enable = 1'b1;
                    ir_latch   = 1'b1;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_enable = 1'b1;
                            mar_latch = 1'b1;
                        end
                        OP_JMP: begin
                            ir_enable = 1'b1;
                            pc_load   = 1'b1;
                        end
                        OP_JZ: begin
                            ir_enable = z_q;
                            pc_load   = z_q;
                        end
                        OP_JC: begin
                            ir_enable = c_q;
                            pc_load   = c_q;
                        end
                        OP_OUT: begin
                            a_enable  = 1'b1;
                            out_latch = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ram_enable = 1'b1;
                        a_latch    = 1'b1;
                    end else if (is_arith) begin
                        ram_enable = 1'b1;
                        b_latch    = 1'b1;
                    end
                end
                T6: begin
                    if (is_arith) begin
                        alu_enable = 1'b1;
                        a_latch    = 1'b1;
                        alu_sub    = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign t_state = state_q;
    assign halt    = halt_q;
    assign c_flag  = c_q;
    assign z_flag  = z_q;

endmodule
